apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Two-requester APB master: arbitrates between requester 0 (host/test sequencer) and requester 1 (UART/GPIO service path).
- Sequences one shared APB3 bus (SETUP/ACCESS) towards the UART and GPIO slaves.
- Round-robin fairness; a timeout converts a hung slave into an error completion.
- Sits between the requesters and the APB slave mux, clocked on PCLK.

Parameters:
- ADDR_W, 32, address width of requests and PADDR.
- DATA_W, 32, data width of wdata/rdata/PWDATA/PRDATA.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before a forced error completion (>=2).

Ports:
- PCLK  in  1  bus clock; all state on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a transfer pending; held until req0_accept.
- req0_write  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  transfer address.
- req0_wdata  in  DATA_W  write data.
- req0_accept  out  1  one-cycle pulse: request latched.
- req0_done  out  1  one-cycle pulse: transfer complete.
- req0_rdata  out  DATA_W  read data; valid with req0_done.
- req0_err  out  1  PSLVERR or timeout; valid with req0_done.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_accept, req1_done, req1_rdata, req1_err: same as requester 0.
- PSEL  out  1  slave select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  direction.
- PADDR  out  ADDR_W  address.
- PWDATA  out  DATA_W  write data.
- PRDATA  in  DATA_W  slave read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (asynchronous, PRESETn=0):
  - State=IDLE.
  - PSEL, PENABLE, PWRITE, accept/done/err = 0.
  - PADDR, PWDATA, rdata = 0.
  - last_grant = 1, so requester 0 wins first.
  - Timeout counter = 0.
  - Reset mid-transfer aborts it silently: no done pulse, and the requester must re-issue.
- States: IDLE, SETUP, ACCESS.
- Arbitration (in IDLE, or in ACCESS on the completion cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On grant: pulse reqN_accept that cycle, latch write/addr/wdata into PWRITE/PADDR/PWDATA, set owner and last_grant, go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, and the counter increments each cycle.
- Completion when PREADY=1:
  - Pulse owner's done.
  - Owner's err = PSLVERR.
  - Owner's rdata = PRDATA for reads, 0 for writes; rdata holds until the owner's next done.
  - Counter clears.
  - If either valid is high in that cycle, arbitrate and go directly to SETUP (back-to-back, 2 cycles per zero-wait transfer). Otherwise drop PSEL/PENABLE and go to IDLE.
- Timeout: counter reaches TIMEOUT-1 with PREADY=0.
  - Complete with err=1, rdata=0.
  - Then same next-state rule as a normal completion.
  - A PREADY arriving on that same cycle takes priority as a normal completion.
- PADDR, PWRITE and PWDATA are stable from SETUP through the completion cycle.
- The non-owner's done/accept stay 0 throughout.
- A requester dropping valid before accept is legal: no transfer occurs.
- Latency for a zero-wait transfer: accept at cycle t, SETUP at t+1, ACCESS and done at t+2.

Decomposition:
- Shared package apb_pkg:
  - state encoding (IDLE/SETUP/ACCESS);
  - APB_ADDR_W/APB_DATA_W defaults;
  - requester index constants REQ0/REQ1;
  - UART/GPIO base-address constants used by benches.
- One natural sub-module, rr_arbiter2: the 2-way round-robin grant logic with last_grant register.

Test Plan:
1. Requester 0 only: read 0x0000_0010, PREADY tied 1, PRDATA=0xA5A5_0001 -> PSEL at t+1, PENABLE at t+2; req0_done at t+2 with rdata=0xA5A5_0001, err=0.
2. Both valid from reset: writes 0x11/0x22 -> grant order req0, req1, req0 on re-request; back-to-back with no IDLE cycle; PWDATA matches each owner.
3. Wait states: PREADY low for 5 ACCESS cycles, PSLVERR=1 at completion -> done after 6 ACCESS cycles, err=1, PADDR stable throughout.
4. Hung slave (PREADY=0 forever), TIMEOUT=16 -> done on the 16th ACCESS cycle with err=1, rdata=0; the next queued request then proceeds normally.
5. PRESETn asserted during ACCESS of req1's write -> PSEL/PENABLE drop immediately (asynchronously), no req1_done; after release, req0 wins the first arbitration.
6. Same-cycle PREADY and timeout (PREADY=1 on cycle 16) -> normal completion with err=PSLVERR=0 and rdata=PRDATA.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// Shared APB definitions: FSM states, default widths,
// requester indices and slave base addresses.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [31:0] UART_BASE = 32'h1000_0000;
  localparam logic [31:0] GPIO_BASE = 32'h1000_1000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last_grant advances on en.
// Ports: clk, rst_n, req[1:0], en -> gnt_idx, gnt_any.
module rr_arbiter2
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic last_grant;

  assign gnt_any = |req;

  always_comb begin
    gnt_idx = REQ0;
    unique case (req)
      2'b11:   gnt_idx = ~last_grant;
      2'b10:   gnt_idx = REQ1;
      default: gnt_idx = REQ0;
    endcase
  end

  // Reset to REQ1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
    end else if (en && gnt_any) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB3 master with round-robin and timeout.
// Ports: PCLK/PRESETn, req0_*/req1_* handshakes, APB bus.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_accept,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_accept,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CW = $clog2(TIMEOUT);

  apb_state_e        state;
  logic              owner;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              access;
  logic              timeout;
  logic              complete;
  logic              arb_en;
  logic              take;
  logic              gnt_idx;
  logic              gnt_any;
  logic              comp_err;
  logic [DATA_W-1:0] comp_rdata;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     ({req1_valid, req0_valid}),
    .en      (arb_en),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // PREADY on the last allowed cycle wins over timeout.
  assign access   = (state == ST_ACCESS);
  assign timeout  = access && !PREADY && (cnt == CW'(TIMEOUT - 1));
  assign complete = access && (PREADY || timeout);
  assign arb_en   = PRESETn && ((state == ST_IDLE) || complete);
  assign take     = arb_en && gnt_any;

  assign comp_err   = !PREADY || PSLVERR;
  assign comp_rdata = (PREADY && !PWRITE) ? PRDATA : '0;

  assign sel_write = gnt_idx ? req1_write : req0_write;
  assign sel_addr  = gnt_idx ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_idx ? req1_wdata : req0_wdata;

  assign req0_accept = take && (gnt_idx == REQ0);
  assign req1_accept = take && (gnt_idx == REQ1);
  assign req0_done   = complete && (owner == REQ0);
  assign req1_done   = complete && (owner == REQ1);
  assign req0_err    = req0_done && comp_err;
  assign req1_err    = req1_done && comp_err;
  assign req0_rdata  = req0_done ? comp_rdata : rdata0_q;
  assign req1_rdata  = req1_done ? comp_rdata : rdata1_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      owner    <= REQ0;
      cnt      <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (take) begin
        PWRITE <= sel_write;
        PADDR  <= sel_addr;
        PWDATA <= sel_wdata;
        owner  <= gnt_idx;
      end
      unique case (state)
        ST_IDLE: begin
          if (take) begin
            state   <= ST_SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
          cnt     <= '0;
        end
        ST_ACCESS: begin
          if (complete) begin
            cnt <= '0;
            if (owner == REQ0) rdata0_q <= comp_rdata;
            else               rdata1_q <= comp_rdata;
            if (take) begin
              state   <= ST_SETUP;
              PENABLE <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
